csr_access_unit: RTL and testbench

CSR_ACCESS_UNIT -- requirements
Module: csr_access_unit

---
 rtl/csr_access_unit.sv | 188 ++++++++++++++++++
 tb/tb_csr_access_unit.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_access_unit.sv
// csr_access_unit
//   Sequences one Zicsr instruction at a time against a CSR file.
//   Each instruction is read first, then optionally written or modified,
//   and the pre-write value is returned on a response handshake.
//   Flow: IDLE -> READ -> (WRITE) -> RESP -> IDLE. An illegal funct3 goes
//   straight from IDLE to RESP and never touches the CSR file.
//
// Optional feature: define CSR_READONLY_TRAP_EN to flag any instruction that
//   would write a read-only CSR (addr[11:10] == 2'b11) as illegal instead of
//   issuing the write. Left undefined, read-only addresses behave like any
//   other address.
//
// Ports
//   clk, rst_n        : clock, asynchronous active-low reset
//   req_valid/ready   : instruction handshake (ready only while idle)
//   req_funct3        : 001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI
//   req_addr          : CSR address
//   req_rs1_idx       : rs1 index, or uimm for the immediate forms
//   req_rs1_data      : rs1 value
//   req_rd            : destination register index
//   csr_addr          : address to the CSR file
//   csr_op            : 00 read, 01 write, 10 set, 11 clear
//   csr_write_data    : operand for write/set/clear (0 otherwise)
//   csr_read_data     : combinational read data from the CSR file
//   csr_error         : CSR file flags an unimplemented address
//   rsp_valid/ready   : response handshake
//   rsp_rd, rsp_data, rsp_we, rsp_illegal : response payload
module csr_access_unit #(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [2:0]            req_funct3,
  input  logic [11:0]           req_addr,
  input  logic [4:0]            req_rs1_idx,
  input  logic [DATA_WIDTH-1:0] req_rs1_data,
  input  logic [4:0]            req_rd,
  output logic [11:0]           csr_addr,
  output logic [1:0]            csr_op,
  output logic [DATA_WIDTH-1:0] csr_write_data,
  input  logic [DATA_WIDTH-1:0] csr_read_data,
  input  logic                  csr_error,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [4:0]            rsp_rd,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_we,
  output logic                  rsp_illegal
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t                state_reg;

  // Fields latched at acceptance
  logic [11:0]           addr_reg;
  logic [4:0]            rd_reg;
  logic [1:0]            op_reg;       // funct3[1:0] doubles as the csr_op code
  logic [DATA_WIDTH-1:0] operand_reg;
  logic                  do_write_reg;
  logic                  do_read_reg;
  logic [DATA_WIDTH-1:0] read_data_reg; // pre-write value held across WRITE

  // Decode of the offered instruction
  logic [1:0]            req_kind;
  logic                  req_bad;
  logic [DATA_WIDTH-1:0] req_operand;
  logic                  req_do_write;
  logic                  req_do_read;
  logic                  ro_trap;

  // funct3[2] selects the immediate form; funct3[1:0] == 00 is not a CSR op.
  assign req_kind     = req_funct3[1:0];
  assign req_bad      = (req_kind == 2'b00);
  assign req_operand  = req_funct3[2] ? {{(DATA_WIDTH-5){1'b0}}, req_rs1_idx}
                                      : req_rs1_data;
  // Set/clear with a zero source are pure reads; rd==0 suppresses the read
  // side effect only for the plain write forms.
  assign req_do_write = (req_kind == 2'b01) || (req_rs1_idx != 5'd0);
  assign req_do_read  = !((req_kind == 2'b01) && (req_rd == 5'd0));

`ifdef CSR_READONLY_TRAP_EN
  assign ro_trap = do_write_reg && (addr_reg[11:10] == 2'b11);
`else
  assign ro_trap = 1'b0;
`endif

  assign req_ready = (state_reg == IDLE);
  assign csr_addr  = addr_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      addr_reg       <= '0;
      rd_reg         <= '0;
      op_reg         <= '0;
      operand_reg    <= '0;
      do_write_reg   <= 1'b0;
      do_read_reg    <= 1'b0;
      read_data_reg  <= '0;
      csr_op         <= 2'b00;
      csr_write_data <= '0;
      rsp_valid      <= 1'b0;
      rsp_rd         <= '0;
      rsp_data       <= '0;
      rsp_we         <= 1'b0;
      rsp_illegal    <= 1'b0;
    end else begin
      unique case (state_reg)
        IDLE: begin
          if (req_valid) begin
            addr_reg     <= req_addr;
            rd_reg       <= req_rd;
            op_reg       <= req_kind;
            operand_reg  <= req_operand;
            do_write_reg <= req_do_write;
            do_read_reg  <= req_do_read;
            if (req_bad) begin
              state_reg   <= RESP;
              rsp_valid   <= 1'b1;
              rsp_illegal <= 1'b1;
              rsp_data    <= '0;
              rsp_we      <= 1'b0;
              rsp_rd      <= req_rd;
            end else begin
              state_reg <= READ;
            end
          end
        end

        READ: begin
          read_data_reg <= csr_read_data;
          if (csr_error || ro_trap) begin
            state_reg   <= RESP;
            rsp_valid   <= 1'b1;
            rsp_illegal <= 1'b1;
            rsp_data    <= '0;
            rsp_we      <= 1'b0;
            rsp_rd      <= rd_reg;
          end else if (do_write_reg) begin
            state_reg      <= WRITE;
            csr_op         <= op_reg;
            csr_write_data <= operand_reg;
          end else begin
            state_reg   <= RESP;
            rsp_valid   <= 1'b1;
            rsp_illegal <= 1'b0;
            rsp_data    <= csr_read_data;
            rsp_we      <= do_read_reg && (rd_reg != 5'd0);
            rsp_rd      <= rd_reg;
          end
        end

        WRITE: begin
          state_reg      <= RESP;
          csr_op         <= 2'b00;
          csr_write_data <= '0;
          rsp_valid      <= 1'b1;
          rsp_illegal    <= 1'b0;
          rsp_data       <= read_data_reg;
          rsp_we         <= do_read_reg && (rd_reg != 5'd0);
          rsp_rd         <= rd_reg;
        end

        RESP: begin
          if (rsp_ready) begin
            state_reg   <= IDLE;
            rsp_valid   <= 1'b0;
            rsp_illegal <= 1'b0;
            rsp_data    <= '0;
            rsp_we      <= 1'b0;
            rsp_rd      <= '0;
          end
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_csr_access_unit.sv
// tb_csr_access_unit
//   Randomized bench for csr_access_unit. A small CSR file (16 entries,
//   indexed by addr[3:0], addresses 0x7Cx unimplemented) sits around the
//   DUT. A reference model computes, per instruction, the cycle-by-cycle
//   timeline of expected outputs from the instruction semantics; one
//   compare process checks the DUT against that timeline every cycle.
module tb_csr_access_unit;

  localparam int DW = 64;

  logic          clk;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic [2:0]    req_funct3;
  logic [11:0]   req_addr;
  logic [4:0]    req_rs1_idx;
  logic [DW-1:0] req_rs1_data;
  logic [4:0]    req_rd;
  logic [11:0]   csr_addr;
  logic [1:0]    csr_op;
  logic [DW-1:0] csr_write_data;
  logic [DW-1:0] csr_read_data;
  logic          csr_error;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [4:0]    rsp_rd;
  logic [DW-1:0] rsp_data;
  logic          rsp_we;
  logic          rsp_illegal;

  csr_access_unit #(.DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_rs1_idx(req_rs1_idx), .req_rs1_data(req_rs1_data),
    .req_rd(req_rd),
    .csr_addr(csr_addr), .csr_op(csr_op), .csr_write_data(csr_write_data),
    .csr_read_data(csr_read_data), .csr_error(csr_error),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rd(rsp_rd),
    .rsp_data(rsp_data), .rsp_we(rsp_we), .rsp_illegal(rsp_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- CSR file environment ----------------
  logic [DW-1:0] env_mem [16];
  logic          ld_en;
  logic [3:0]    ld_idx;
  logic [DW-1:0] ld_val;

  assign csr_read_data = env_mem[csr_addr[3:0]];
  assign csr_error     = (csr_addr[11:4] == 8'h7C);

  always @(posedge clk) begin
    if (ld_en) env_mem[ld_idx] <= ld_val;
    else if (rst_n) begin
      case (csr_op)
        2'b01:   env_mem[csr_addr[3:0]] <= csr_write_data;
        2'b10:   env_mem[csr_addr[3:0]] <= env_mem[csr_addr[3:0]] | csr_write_data;
        2'b11:   env_mem[csr_addr[3:0]] <= env_mem[csr_addr[3:0]] & ~csr_write_data;
        default: ;
      endcase
    end
  end

  // ---------------- reference model ----------------
  typedef struct {
    logic          req_valid;
    logic [2:0]    f3;
    logic [11:0]   addr;
    logic [4:0]    idx;
    logic [DW-1:0] rs1;
    logic [4:0]    rd;
    logic          rsp_ready;
    logic          e_req_ready;
    logic          e_addr_chk;
    logic [11:0]   e_addr;
    logic [1:0]    e_op;
    logic [DW-1:0] e_wdata;
    logic          e_rsp_valid;
    logic          e_rsp_chk;
    logic [4:0]    e_rsp_rd;
    logic [DW-1:0] e_rsp_data;
    logic          e_rsp_we;
    logic          e_rsp_illegal;
  } cyc_t;

  logic [DW-1:0] ref_mem [16];
  cyc_t          tl[$];
  cyc_t          cur;
  logic          chk_en;
  logic          pend_valid;
  logic [3:0]    pend_idx;
  logic [DW-1:0] pend_val;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle with no outstanding instruction: block is idle and ready.
  function automatic cyc_t idle_cyc();
    cyc_t c;
    c.req_valid     = 1'b0;
    c.f3            = 3'($urandom);
    c.addr          = 12'($urandom);
    c.idx           = 5'($urandom);
    c.rs1           = {$urandom, $urandom};
    c.rd            = 5'($urandom);
    c.rsp_ready     = 1'($urandom);
    c.e_req_ready   = 1'b1;
    c.e_addr_chk    = 1'b0;
    c.e_addr        = '0;
    c.e_op          = 2'b00;
    c.e_wdata       = '0;
    c.e_rsp_valid   = 1'b0;
    c.e_rsp_chk     = 1'b0;
    c.e_rsp_rd      = '0;
    c.e_rsp_data    = '0;
    c.e_rsp_we      = 1'b0;
    c.e_rsp_illegal = 1'b0;
    return c;
  endfunction

  // Cycle while an instruction is in flight: offers are ignored.
  function automatic cyc_t busy_cyc();
    cyc_t c;
    c = idle_cyc();
    c.req_valid   = 1'($urandom);
    c.e_req_ready = 1'b0;
    return c;
  endfunction

  // Build the expected timeline of one instruction, starting at its accept
  // cycle, with `stall` cycles of rsp_ready low before the handshake.
  task automatic build(input logic [2:0] f3, input logic [11:0] a, input logic [4:0] idx,
                       input logic [DW-1:0] rs1, input logic [4:0] rd, input int stall);
    cyc_t          c;
    logic [DW-1:0] rv, opnd, nv;
    logic          wr, rdn, ro, ill;
    tl.delete();
    pend_valid = 1'b0;
    c = idle_cyc();
    c.req_valid = 1'b1; c.f3 = f3; c.addr = a; c.idx = idx; c.rs1 = rs1; c.rd = rd;
    tl.push_back(c);
    rv = '0; rdn = 1'b0; ill = 1'b1;
    if (f3[1:0] != 2'b00) begin
      rv   = ref_mem[a[3:0]];
      opnd = f3[2] ? DW'(idx) : rs1;
      wr   = (f3[1:0] == 2'b01) || (idx != 5'd0);
      rdn  = !((f3[1:0] == 2'b01) && (rd == 5'd0));
      ro   = 1'b0;
`ifdef CSR_READONLY_TRAP_EN
      ro   = wr && (a[11:10] == 2'b11);
`endif
      ill  = (a[11:4] == 8'h7C) || ro;
      c = busy_cyc(); c.e_addr_chk = 1'b1; c.e_addr = a;
      tl.push_back(c);
      if (!ill && wr) begin
        c = busy_cyc(); c.e_addr_chk = 1'b1; c.e_addr = a;
        c.e_op = f3[1:0]; c.e_wdata = opnd;
        tl.push_back(c);
        case (f3[1:0])
          2'b01:   nv = opnd;
          2'b10:   nv = rv | opnd;
          default: nv = rv & ~opnd;
        endcase
        pend_valid = 1'b1; pend_idx = a[3:0]; pend_val = nv;
      end
    end
    for (int s = 0; s <= stall; s++) begin
      c = busy_cyc();
      c.rsp_ready     = (s == stall);
      c.e_rsp_valid   = 1'b1;
      c.e_rsp_chk     = 1'b1;
      c.e_rsp_rd      = rd;
      c.e_rsp_data    = ill ? '0 : rv;
      c.e_rsp_we      = rdn && !ill && (rd != 5'd0);
      c.e_rsp_illegal = ill;
      tl.push_back(c);
    end
  endtask

  task automatic drive_cyc(input cyc_t c);
    @(negedge clk);
    ld_en        = 1'b0;
    req_valid    = c.req_valid;
    req_funct3   = c.f3;
    req_addr     = c.addr;
    req_rs1_idx  = c.idx;
    req_rs1_data = c.rs1;
    req_rd       = c.rd;
    rsp_ready    = c.rsp_ready;
    cur          = c;
    chk_en       = 1'b1;
    $display("cycle t=%0t req_valid=%0b f3=%03b addr=%03h rsp_ready=%0b", $time,
             c.req_valid, c.f3, c.addr, c.rsp_ready);
  endtask

  task automatic run_n(input int n);
    for (int i = 0; i < n; i++) drive_cyc(tl[i]);
  endtask

  task automatic run();
    run_n(tl.size());
    if (pend_valid) ref_mem[pend_idx] = pend_val;
    $display("tx done: %0d cycles", tl.size());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive_cyc(idle_cyc());
  endtask

  task automatic preload(input logic [3:0] idx, input logic [DW-1:0] val);
    drive_cyc(idle_cyc());
    ld_en  = 1'b1;
    ld_idx = idx;
    ld_val = val;
    ref_mem[idx] = val;
  endtask

  function automatic logic [11:0] pick_addr();
    logic [3:0] hi;
    case ($urandom_range(0, 3))
      0:       hi = 4'h3;
      1:       hi = 4'h7;
      2:       hi = 4'hB;
      default: hi = 4'hC;
    endcase
    return {hi, ($urandom_range(0, 1) == 0) ? 4'h0 : 4'hC, 4'($urandom)};
  endfunction

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    #2;
    if (chk_en) begin
      chk("req_ready", DW'(req_ready), DW'(cur.e_req_ready));
      chk("csr_op", DW'(csr_op), DW'(cur.e_op));
      chk("csr_write_data", csr_write_data, cur.e_wdata);
      chk("rsp_valid", DW'(rsp_valid), DW'(cur.e_rsp_valid));
      if (cur.e_addr_chk) chk("csr_addr", DW'(csr_addr), DW'(cur.e_addr));
      if (cur.e_rsp_chk) begin
        chk("rsp_rd", DW'(rsp_rd), DW'(cur.e_rsp_rd));
        chk("rsp_data", rsp_data, cur.e_rsp_data);
        chk("rsp_we", DW'(rsp_we), DW'(cur.e_rsp_we));
        chk("rsp_illegal", DW'(rsp_illegal), DW'(cur.e_rsp_illegal));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // ---------------- stimulus ----------------
  initial begin
    int stall;
    logic [4:0] idx, rd;
    chk_en = 1'b0; ld_en = 1'b0; ld_idx = '0; ld_val = '0;
    rst_n = 1'b0; req_valid = 1'b0; req_funct3 = '0; req_addr = '0;
    req_rs1_idx = '0; req_rs1_data = '0; req_rd = '0; rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    chk("rst_csr_op", DW'(csr_op), '0);
    chk("rst_csr_addr", DW'(csr_addr), '0);
    chk("rst_csr_write_data", csr_write_data, '0);
    chk("rst_rsp_valid", DW'(rsp_valid), '0);
    chk("rst_rsp_we", DW'(rsp_we), '0);
    chk("rst_rsp_illegal", DW'(rsp_illegal), '0);
    chk("rst_rsp_data", rsp_data, '0);
    chk("rst_rsp_rd", DW'(rsp_rd), '0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) preload(4'(i), {$urandom, $urandom});
    idle(2);

    // CSRRS rs1=0: read only, response at cycle 2
    preload(4'h0, 64'h1234);
    build(3'b010, 12'hC00, 5'd0, {$urandom, $urandom}, 5'd5, 0);
    chk("m040_len", DW'(tl.size()), 64'd3);
    chk("m040_data", tl[2].e_rsp_data, 64'h1234);
    chk("m040_we", DW'(tl[2].e_rsp_we), 64'd1);
    run();

    // CSRRW rd=0: one write cycle, no register write-back, response at cycle 3
    build(3'b001, 12'hB03, 5'd7, 64'hAA, 5'd0, 0);
    chk("m041_len", DW'(tl.size()), 64'd4);
    chk("m041_op", DW'(tl[2].e_op), 64'd1);
    chk("m041_wdata", tl[2].e_wdata, 64'hAA);
    chk("m041_we", DW'(tl[3].e_rsp_we), 64'd0);
    run();

    // CSRRCI uimm=5
    preload(4'h5, 64'hFF);
    build(3'b111, 12'hB05, 5'd5, {$urandom, $urandom}, 5'd3, 0);
    chk("m042_op", DW'(tl[2].e_op), 64'd3);
    chk("m042_wdata", tl[2].e_wdata, 64'h5);
    chk("m042_data", tl[3].e_rsp_data, 64'hFF);
    run();
    chk("m042_mem", ref_mem[5], 64'hFA);

    // unimplemented address
    build(3'b001, 12'h7C0, 5'd9, 64'h55, 5'd4, 0);
    chk("m043_len", DW'(tl.size()), 64'd3);
    chk("m043_illegal", DW'(tl[2].e_rsp_illegal), 64'd1);
    chk("m043_data", tl[2].e_rsp_data, 64'd0);
    run();

    // response back-pressure, then illegal funct3
    build(3'b010, 12'h305, 5'd0, 64'd0, 5'd6, 3);
    chk("m044_len", DW'(tl.size()), 64'd6);
    run();
    build(3'b100, 12'h300, 5'd1, 64'd1, 5'd7, 0);
    chk("m044_ill_len", DW'(tl.size()), 64'd2);
    chk("m044_ill", DW'(tl[1].e_rsp_illegal), 64'd1);
    run();

    // write to a read-only address
    build(3'b001, 12'hC01, 5'd3, 64'h77, 5'd8, 0);
`ifdef CSR_READONLY_TRAP_EN
    chk("m045_len", DW'(tl.size()), 64'd3);
    chk("m045_ill", DW'(tl[2].e_rsp_illegal), 64'd1);
`else
    chk("m045_len", DW'(tl.size()), 64'd4);
    chk("m045_op", DW'(tl[2].e_op), 64'd1);
`endif
    run();

    // reset asserted during the WRITE cycle: the write must be dropped
    build(3'b001, 12'h302, 5'd1, 64'hDEAD, 5'd2, 0);
    run_n(2);
    @(negedge clk);
    chk_en = 1'b0; req_valid = 1'b0;
    #1;
    chk("midrst_write_seen", DW'(csr_op), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_csr_op", DW'(csr_op), '0);
    chk("midrst_wdata", csr_write_data, '0);
    chk("midrst_rsp_valid", DW'(rsp_valid), '0);
    chk("midrst_csr_addr", DW'(csr_addr), '0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);
    build(3'b010, 12'h302, 5'd0, 64'd0, 5'd1, 0);
    run();

    // randomized traffic
    for (int t = 0; t < 150; t++) begin
      idx   = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      rd    = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      stall = $urandom_range(0, 2);
      build(3'($urandom), pick_addr(), idx, {$urandom, $urandom}, rd, stall);
      run();
      idle($urandom_range(0, 2));
    end

    idle(1);
    @(negedge clk);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
